sdram_init_ctrl: RTL
====================

# sdram_init_ctrl

Parametrised SDRAM power-up initialisation sequencer driving the command, bank and address pins between reset release and the first user access. It runs the power-up wait, then PRECHARGE ALL, a configurable number of AUTO REFRESH commands and LOAD MODE REGISTER, and then signals completion to the arbiter. Unlike the fixed-timing initialiser, all timings and mode fields are parameters. A re-initialisation request re-runs the sequence without the power-up wait.

## Interface
- CLK_PERIOD_NS, 10, clock period in ns
- T_POWERUP_US, 200, power-up NOP wait in µs; PWR_CYC = T_POWERUP_US*1000/CLK_PERIOD_NS
- T_RP_CYC, 2, cycles from PRECHARGE to next command (≥1)
- T_RFC_CYC, 7, cycles from AUTO REFRESH to next command (≥1)
- T_MRD_CYC, 2, cycles from LOAD MODE to done (≥1)
- AREF_NUM, 8, AUTO REFRESH count (≥1)
- ADDR_W, 13, address width (≥11)
- BA_W, 2, bank address width
- CAS_LAT, 3, CAS latency field (3 bits)
- BURST_LEN, 3'b011, burst length field A2:A0
- BURST_TYPE, 1'b0, A3 (0 sequential)
- sysclk_100M  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- reinit_req  in  1  one-cycle request to re-run the sequence
- cmd_reg  out  4  {CS_n,RAS_n,CAS_n,WE_n}
- sdram_ba  out  BA_W  bank address
- sdram_addr  out  ADDR_W  address / mode word
- init_end_flag  out  1  high while initialised

## Operation
- Commands: NOP 4'b0111, PRECHARGE 4'b0010, AUTO_REFRESH 4'b0001, LOAD_MODE 4'b0000.
- States: WAIT_PWR → PRECH → WAIT_RP → AREF → WAIT_RFC → (AREF again until AREF_NUM issued) → LMR → WAIT_MRD → DONE.
- Each command drives cmd_reg for exactly one cycle; all other cycles are NOP.
- PRECHARGE: sdram_addr[10]=1 (all banks), other bits 0, ba=0.
- AREF/NOP: addr=0, ba=0.
- LOAD_MODE: ba=0, addr={zeros(ADDR_W-10), A9=0, A8:7=00, CAS_LAT, BURST_TYPE, BURST_LEN}; defaults give 13'h033.
- Refresh counter counts issued AUTO REFRESH commands; it leaves WAIT_RFC for LMR when the count reaches AREF_NUM.
- DONE: init_end_flag=1 and NOP held indefinitely.
- Re-initialisation:
  - reinit_req sampled in DONE: the next cycle is PRECH (cmd=PRECHARGE) with init_end_flag=0, and the refresh counter is cleared.
  - reinit_req outside DONE is ignored. There is no queueing.
- Reset mid-sequence (any state): full restart from WAIT_PWR, including the complete power-up wait.

## Timing
- All outputs are registered.
- Reset values: cmd_reg=4'b0111, sdram_ba=0, sdram_addr=0, init_end_flag=0, state=WAIT_PWR, counters 0.
- Cycle 0 is the first rising edge with rst_n=1.
  - PRECHARGE appears at cycle PWR_CYC.
  - First AREF appears T_RP_CYC later; subsequent AREFs are spaced T_RFC_CYC apart.
  - LMR appears T_RFC_CYC after the last AREF.
  - init_end_flag rises T_MRD_CYC after LMR.
- Defaults: PRECHARGE at 20000, AREF at 20002, 20009, …, 20051; LMR at 20058; init_end_flag=1 from 20060.
- Re-init latency: reinit_req at cycle n gives PRECHARGE at n+1, then the same relative spacing, with init_end_flag=1 at n+61.
- Wait counters size to $clog2 of the largest wait and must never wrap.

## Configuration
- SDRAM_INIT_EMRS_EN defined:
  - Adds parameter EMR_VAL (ADDR_W bits, default 0).
  - After WAIT_MRD, issues a second LOAD_MODE with sdram_ba=2'b10 and addr=EMR_VAL.
  - Then waits T_MRD_CYC before DONE; with defaults, init_end_flag rises at 20062.
- Undefined: no extended mode register cycle; the timing is exactly as above.

## Structure
- Package sdram_pkg holds:
  - command constants (CMD_NOP, CMD_PRECH, CMD_AREF, CMD_LMR);
  - the init state enum;
  - the A10 precharge-all bit index.
- One sub-module, sdram_delay_cnt: a loadable down-counter with a done pulse, instantiated once and reloaded per wait state.

## Test plan
- Defaults, reset released at cycle 0 → PRECHARGE at 20000 with addr[10]=1; 8 AREFs at 20002+7k; LMR at 20058 with addr=13'h033; init_end_flag=1 at 20060; NOP on all other cycles.
- Parameters AREF_NUM=2, T_POWERUP_US=1 → PRECHARGE at 100, AREF at 102 and 109, LMR at 116, done at 118.
- reinit_req pulse 50 cycles after done → init_end_flag falls next cycle with PRECHARGE; no power-up wait; done again after 61 cycles.
- reinit_req during AREF phase → ignored; schedule unchanged.
- rst_n low for 1 cycle during the 4th AREF wait → outputs reset, PRECHARGE at 20000 cycles after release.
- SDRAM_INIT_EMRS_EN with EMR_VAL=13'h020 → second LOAD_MODE at 20060 with ba=2'b10, addr=13'h020; done at 20062.

Source files
------------

// File: rtl/sdram_pkg.sv
// Shared constants and state encoding for the SDRAM power-up initialisation sequencer.
package sdram_pkg;

    // Command pin order is {CS_n, RAS_n, CAS_n, WE_n}
    localparam logic [3:0] CMD_NOP   = 4'b0111;
    localparam logic [3:0] CMD_PRECH = 4'b0010;
    localparam logic [3:0] CMD_AREF  = 4'b0001;
    localparam logic [3:0] CMD_LMR   = 4'b0000;

    localparam int A10_IDX = 10;

    typedef enum logic [3:0] {
        ST_WAIT_PWR,
        ST_PRECH,
        ST_WAIT_RP,
        ST_AREF,
        ST_WAIT_RFC,
        ST_LMR,
        ST_WAIT_MRD,
        ST_EMRS,
        ST_WAIT_EMRD,
        ST_DONE
    } init_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sdram_init_ctrl_if.sv
// Command/address bus between the initialisation sequencer (master) and the SDRAM/arbiter side (slave).
interface sdram_init_ctrl_if #(
    parameter int ADDR_W = 13,
    parameter int BA_W   = 2
);
    logic              reinit_req;
    logic [3:0]        cmd_reg;
    logic [BA_W-1:0]   sdram_ba;
    logic [ADDR_W-1:0] sdram_addr;
    logic              init_end_flag;

    modport master (
        input  reinit_req,
        output cmd_reg, sdram_ba, sdram_addr, init_end_flag
    );

    modport slave (
        output reinit_req,
        input  cmd_reg, sdram_ba, sdram_addr, init_end_flag
    );
endinterface

// File: rtl/sdram_delay_cnt.sv
// Loadable down-counter; done is high during the last cycle of a loaded wait of N cycles.
module sdram_delay_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);
    logic [W-1:0] cnt_q, cnt_d;

    // Saturates at zero so an unserviced wait can never wrap into a spurious done.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == W'(1));

endmodule

// File: rtl/sdram_init_ctrl.sv
// Parametrised SDRAM power-up initialiser: power-up wait, PRECHARGE ALL, AUTO REFRESH x N, LOAD MODE.
// Define SDRAM_INIT_EMRS_EN to add an extended mode register load (EMR_VAL) before completion.
module sdram_init_ctrl
    import sdram_pkg::*;
#(
    parameter int          CLK_PERIOD_NS = 10,
    parameter int          T_POWERUP_US  = 200,
    parameter int          T_RP_CYC      = 2,
    parameter int          T_RFC_CYC     = 7,
    parameter int          T_MRD_CYC     = 2,
    parameter int          AREF_NUM      = 8,
    parameter int          ADDR_W        = 13,
    parameter int          BA_W          = 2,
    parameter logic [2:0]  CAS_LAT       = 3'd3,
    parameter logic [2:0]  BURST_LEN     = 3'b011,
    parameter logic        BURST_TYPE    = 1'b0
`ifdef SDRAM_INIT_EMRS_EN
    ,
    parameter logic [ADDR_W-1:0] EMR_VAL = '0
`endif
) (
    input  logic               sysclk_100M,
    input  logic               rst_n,
    sdram_init_ctrl_if.master  bus
);
    localparam int PWR_CYC  = T_POWERUP_US * 1000 / CLK_PERIOD_NS;
    localparam int MAX_WAIT = max_int(max_int(PWR_CYC, T_RP_CYC), max_int(T_RFC_CYC, T_MRD_CYC));
    localparam int CNT_W    = $clog2(MAX_WAIT + 1);
    localparam int AREF_W   = $clog2(AREF_NUM + 1);

    localparam logic [ADDR_W-1:0] MODE_WORD = ADDR_W'({3'b000, CAS_LAT, BURST_TYPE, BURST_LEN});
    localparam logic [ADDR_W-1:0] PALL_WORD = {{(ADDR_W-1){1'b0}}, 1'b1} << A10_IDX;

    init_state_e       state_q, state_d;
    logic [3:0]        cmd_q, cmd_d;
    logic [BA_W-1:0]   ba_q, ba_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              init_end_q, init_end_d;
    logic [AREF_W-1:0] aref_cnt_q, aref_cnt_d;
    logic              pwr_armed_q, pwr_armed_d;

    logic              dly_load;
    logic [CNT_W-1:0]  dly_val;
    logic              dly_done;
    logic              start_prech;

    sdram_delay_cnt #(.W(CNT_W)) u_delay (
        .clk      (sysclk_100M),
        .rst_n    (rst_n),
        .load     (dly_load),
        .load_val (dly_val),
        .done     (dly_done)
    );

    // Command states share their wait state's logic so a one-cycle wait still works.
    always_comb begin
        state_d     = state_q;
        cmd_d       = CMD_NOP;
        ba_d        = '0;
        addr_d      = '0;
        init_end_d  = init_end_q;
        aref_cnt_d  = aref_cnt_q;
        pwr_armed_d = pwr_armed_q;
        dly_load    = 1'b0;
        dly_val     = '0;
        start_prech = 1'b0;

        case (state_q)
            ST_WAIT_PWR: begin
                if (!pwr_armed_q) begin
                    pwr_armed_d = 1'b1;
                    dly_load    = 1'b1;
                    dly_val     = CNT_W'(PWR_CYC);
                end else if (dly_done) begin
                    start_prech = 1'b1;
                end
            end
            ST_PRECH, ST_WAIT_RP: begin
                state_d = ST_WAIT_RP;
                if (dly_done) begin
                    state_d    = ST_AREF;
                    cmd_d      = CMD_AREF;
                    aref_cnt_d = aref_cnt_q + AREF_W'(1);
                    dly_load   = 1'b1;
                    dly_val    = CNT_W'(T_RFC_CYC);
                end
            end
            ST_AREF, ST_WAIT_RFC: begin
                state_d = ST_WAIT_RFC;
                if (dly_done) begin
                    dly_load = 1'b1;
                    if (aref_cnt_q == AREF_W'(AREF_NUM)) begin
                        state_d = ST_LMR;
                        cmd_d   = CMD_LMR;
                        addr_d  = MODE_WORD;
                        dly_val = CNT_W'(T_MRD_CYC);
                    end else begin
                        state_d    = ST_AREF;
                        cmd_d      = CMD_AREF;
                        aref_cnt_d = aref_cnt_q + AREF_W'(1);
                        dly_val    = CNT_W'(T_RFC_CYC);
                    end
                end
            end
            ST_LMR, ST_WAIT_MRD: begin
                state_d = ST_WAIT_MRD;
                if (dly_done) begin
`ifdef SDRAM_INIT_EMRS_EN
                    state_d  = ST_EMRS;
                    cmd_d    = CMD_LMR;
                    ba_d     = BA_W'(2);
                    addr_d   = EMR_VAL;
                    dly_load = 1'b1;
                    dly_val  = CNT_W'(T_MRD_CYC);
`else
                    state_d    = ST_DONE;
                    init_end_d = 1'b1;
`endif
                end
            end
`ifdef SDRAM_INIT_EMRS_EN
            ST_EMRS, ST_WAIT_EMRD: begin
                state_d = ST_WAIT_EMRD;
                if (dly_done) begin
                    state_d    = ST_DONE;
                    init_end_d = 1'b1;
                end
            end
`endif
            ST_DONE: begin
                if (bus.reinit_req) begin
                    start_prech = 1'b1;
                end
            end
            default: begin
                state_d     = ST_WAIT_PWR;
                pwr_armed_d = 1'b0;
                init_end_d  = 1'b0;
            end
        endcase

        // Shared entry into the sequence from both the power-up wait and a re-init request.
        if (start_prech) begin
            state_d    = ST_PRECH;
            cmd_d      = CMD_PRECH;
            addr_d     = PALL_WORD;
            aref_cnt_d = '0;
            init_end_d = 1'b0;
            dly_load   = 1'b1;
            dly_val    = CNT_W'(T_RP_CYC);
        end
    end

    always_ff @(posedge sysclk_100M) begin
        if (!rst_n) begin
            state_q     <= ST_WAIT_PWR;
            cmd_q       <= CMD_NOP;
            ba_q        <= '0;
            addr_q      <= '0;
            init_end_q  <= 1'b0;
            aref_cnt_q  <= '0;
            pwr_armed_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            ba_q        <= ba_d;
            addr_q      <= addr_d;
            init_end_q  <= init_end_d;
            aref_cnt_q  <= aref_cnt_d;
            pwr_armed_q <= pwr_armed_d;
        end
    end

    assign bus.cmd_reg       = cmd_q;
    assign bus.sdram_ba      = ba_q;
    assign bus.sdram_addr    = addr_q;
    assign bus.init_end_flag = init_end_q;

endmodule
